// File: rtl/stage_write_arb_if.sv
// ---------------------------------------------------------------------------
// stage_write_arb_if
//   Bundles every writeback-stage signal except clock/reset.
//   master : pipeline / mul-div / decode side (drives requests, observes
//            writes, stall and scoreboard)
//   slave  : the stage_write_arb block itself
//
//   pipe_we/pipe_rd/pipe_data        in-order regfile write request
//   pipe_st_we/pipe_st_data          in-order status-register write request
//   md_valid/md_ready/md_rd/md_data/md_exc   mul/div result handshake
//   rf_we/rf_rd/rf_data              registered regfile write port
//   st_we/st_data                    registered status write port
//   wb_stall                         pipeline must present no writes
//   q_rd/q_hit                       pending-destination scoreboard query
//   pend_count                       entries held in the pending FIFO
// ---------------------------------------------------------------------------
interface stage_write_arb_if #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int PEND_DEPTH = 4
);
    localparam int CNT_W = $clog2(PEND_DEPTH) + 1;

    logic              pipe_we;
    logic [REG_AW-1:0] pipe_rd;
    logic [DATA_W-1:0] pipe_data;
    logic              pipe_st_we;
    logic [DATA_W-1:0] pipe_st_data;

    logic              md_valid;
    logic              md_ready;
    logic [REG_AW-1:0] md_rd;
    logic [DATA_W-1:0] md_data;
    logic              md_exc;

    logic              rf_we;
    logic [REG_AW-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              st_we;
    logic [DATA_W-1:0] st_data;

    logic              wb_stall;
    logic [REG_AW-1:0] q_rd;
    logic              q_hit;
    logic [CNT_W-1:0]  pend_count;

    modport master (
        output pipe_we, pipe_rd, pipe_data, pipe_st_we, pipe_st_data,
               md_valid, md_rd, md_data, md_exc, q_rd,
        input  md_ready, rf_we, rf_rd, rf_data, st_we, st_data,
               wb_stall, q_hit, pend_count
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, pipe_st_we, pipe_st_data,
               md_valid, md_rd, md_data, md_exc, q_rd,
        output md_ready, rf_we, rf_rd, rf_data, st_we, st_data,
               wb_stall, q_hit, pend_count
    );
endinterface

// File: rtl/stage_write_arb.sv
// ---------------------------------------------------------------------------
// stage_write_arb
//   Writeback stage merging in-order pipeline results with out-of-order
//   mul/div results onto one regfile write port and one status write port.
//   Mul/div results wait in a small pending FIFO and drain into writeback
//   slots the pipeline leaves free. A head that waits STARVE_LIMIT cycles
//   raises wb_stall so the pipeline yields. The FIFO contents double as a
//   pending-destination scoreboard for decode (q_rd -> q_hit).
//
// Ports:
//   clock  : system clock
//   reset  : synchronous, active-high
//   bus    : stage_write_arb_if.slave (see interface header for signals)
// ---------------------------------------------------------------------------
module stage_write_arb #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int PEND_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int EXC_CODE     = 1
) (
    input  logic              clock,
    input  logic              reset,
    stage_write_arb_if.slave  bus
);
    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              exc;
    } entry_t;

    // FIFO storage and bookkeeping
    entry_t                mem [PEND_DEPTH];
    logic [PEND_DEPTH-1:0] valid;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;

    logic [SC_W-1:0]       starve_cnt;
    logic [SC_W-1:0]       starve_next;

    // Registered write ports
    logic                  rf_we_q;
    logic [REG_AW-1:0]     rf_rd_q;
    logic [DATA_W-1:0]     rf_data_q;
    logic                  st_we_q;
    logic [DATA_W-1:0]     st_data_q;
    logic                  wb_stall_q;

    logic                  fifo_empty;
    logic                  accept;
    logic                  keep;
    logic                  drain;
    logic                  hit;
    entry_t                head;

    // md_ready looks only at the registered count, so a slot freed by a
    // drain this cycle is not reusable until the next one.
    assign bus.md_ready = (cnt < CNT_W'(PEND_DEPTH));
    assign accept       = bus.md_valid && bus.md_ready;
    // rd=0 results without an exception have no architectural effect.
    assign keep         = accept && ((bus.md_rd != '0) || bus.md_exc);

    assign fifo_empty   = (cnt == '0);
    assign head         = mem[rd_ptr];
    // Pipeline always wins; an exception head also needs the status port.
    assign drain        = !fifo_empty && !bus.pipe_we &&
                          !(head.exc && bus.pipe_st_we);

    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_next = cnt;
        case ({keep, drain})
            2'b10:   cnt_next = cnt + 1'b1;
            2'b01:   cnt_next = cnt - 1'b1;
            default: cnt_next = cnt;
        endcase
    end

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || drain) begin
            starve_next = '0;
        end else if (starve_cnt < SC_W'(STARVE_LIMIT)) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (valid[i] && (mem[i].rd == bus.q_rd)) begin
                hit = 1'b1;
            end
        end
    end

    assign bus.q_hit = hit && (bus.q_rd != '0);

    // NOTE: the FIFO payload is deliberately left out of reset; the valid
    // bits and count are reset, so stale payload is never observed and the
    // storage can map onto plain registers or RAM without a reset network.
    always_ff @(posedge clock) begin
        if (keep) begin
            mem[wr_ptr] <= '{rd: bus.md_rd, data: bus.md_data, exc: bus.md_exc};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            starve_cnt <= '0;
            wb_stall_q <= 1'b0;
        end else begin
            // keep and drain never target the same slot: keep implies not
            // full, drain implies not empty, so wr_ptr != rd_ptr.
            if (drain) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (keep) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            cnt        <= cnt_next;
            starve_cnt <= starve_next;
            wb_stall_q <= (starve_next == SC_W'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            st_we_q   <= 1'b0;
            st_data_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            st_we_q <= 1'b0;

            if (bus.pipe_we) begin
                rf_we_q   <= (bus.pipe_rd != '0);
                rf_rd_q   <= bus.pipe_rd;
                rf_data_q <= bus.pipe_data;
            end else if (drain) begin
                // An exception entry with rd=0 still drains for its status write.
                rf_we_q   <= (head.rd != '0);
                rf_rd_q   <= head.rd;
                rf_data_q <= head.data;
            end

            if (bus.pipe_st_we) begin
                st_we_q   <= 1'b1;
                st_data_q <= bus.pipe_st_data;
            end else if (drain && head.exc) begin
                st_we_q   <= 1'b1;
                st_data_q <= DATA_W'(EXC_CODE);
            end
        end
    end

    assign bus.rf_we      = rf_we_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_data    = rf_data_q;
    assign bus.st_we      = st_we_q;
    assign bus.st_data    = st_data_q;
    assign bus.wb_stall   = wb_stall_q;
    assign bus.pend_count = cnt;

endmodule

// File: tb/tb_stage_write_arb.sv
// ---------------------------------------------------------------------------
// tb_stage_write_arb
//   Directed scenarios with literal expectations, then randomized traffic.
//   A queue-based reference model tracks pending results; one compare
//   process checks every DUT output against it on each falling edge.
// ---------------------------------------------------------------------------
module tb_stage_write_arb;
    localparam int DATA_W       = 32;
    localparam int REG_AW       = 5;
    localparam int PEND_DEPTH   = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int EXC_CODE     = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    stage_write_arb_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PEND_DEPTH(PEND_DEPTH)) bus ();

    stage_write_arb #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .PEND_DEPTH(PEND_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT), .EXC_CODE(EXC_CODE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: pending results as a queue, outputs as values.
    // ------------------------------------------------------------------
    typedef struct {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              exc;
    } ent_t;

    ent_t              q[$];
    int                starve = 0;
    bit                model_live = 0;
    bit                m_rf_we, m_st_we, m_stall;
    logic [REG_AW-1:0] m_rf_rd;
    logic [DATA_W-1:0] m_rf_data, m_st_data;
    bit                m_ready, m_can_drain;

    function automatic bit model_hit(input logic [REG_AW-1:0] a);
        if (a == 0) return 1'b0;
        foreach (q[i]) if (q[i].rd == a) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            q.delete();
            starve     = 0;
            m_rf_we    = 0;
            m_rf_rd    = '0;
            m_rf_data  = '0;
            m_st_we    = 0;
            m_st_data  = '0;
            m_stall    = 0;
            model_live = 1;
        end else if (model_live) begin
            m_ready     = (q.size() < PEND_DEPTH);
            m_can_drain = (q.size() != 0) && !bus.pipe_we && !(q[0].exc && bus.pipe_st_we);
            m_rf_we = 0;
            m_st_we = 0;
            if (bus.pipe_we) begin
                m_rf_we   = (bus.pipe_rd != 0);
                m_rf_rd   = bus.pipe_rd;
                m_rf_data = bus.pipe_data;
            end else if (m_can_drain) begin
                m_rf_we   = (q[0].rd != 0);
                m_rf_rd   = q[0].rd;
                m_rf_data = q[0].data;
            end
            if (bus.pipe_st_we) begin
                m_st_we   = 1;
                m_st_data = bus.pipe_st_data;
            end else if (m_can_drain && q[0].exc) begin
                m_st_we   = 1;
                m_st_data = EXC_CODE;
            end
            if (q.size() == 0 || m_can_drain) starve = 0;
            else if (starve < STARVE_LIMIT) starve++;
            m_stall = (starve == STARVE_LIMIT);
            if (m_can_drain) void'(q.pop_front());
            if (bus.md_valid && m_ready && (bus.md_rd != 0 || bus.md_exc))
                q.push_back('{bus.md_rd, bus.md_data, bus.md_exc});
        end
    end

    // Single compare process, mid-cycle.
    always @(negedge clock) begin
        if (model_live) begin
            check("rf_we", bus.rf_we, m_rf_we);
            if (m_rf_we) begin
                check("rf_rd", bus.rf_rd, m_rf_rd);
                check("rf_data", bus.rf_data, m_rf_data);
            end
            check("st_we", bus.st_we, m_st_we);
            if (m_st_we) check("st_data", bus.st_data, m_st_data);
            check("wb_stall", bus.wb_stall, m_stall);
            check("pend_count", bus.pend_count, q.size());
            check("md_ready", bus.md_ready, q.size() < PEND_DEPTH);
            check("q_hit", bus.q_hit, model_hit(bus.q_rd));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle();
        bus.pipe_we      = 1'b0;
        bus.pipe_rd      = '0;
        bus.pipe_data    = '0;
        bus.pipe_st_we   = 1'b0;
        bus.pipe_st_data = '0;
        bus.md_valid     = 1'b0;
        bus.md_rd        = '0;
        bus.md_data      = '0;
        bus.md_exc       = 1'b0;
        bus.q_rd         = '0;
    endtask

    task automatic md(input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] data, input logic exc);
        bus.md_valid = 1'b1;
        bus.md_rd    = rd;
        bus.md_data  = data;
        bus.md_exc   = exc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        // Reset state
        check("rst_rf_we", bus.rf_we, 0);
        check("rst_st_we", bus.st_we, 0);
        check("rst_rf_rd", bus.rf_rd, 0);
        check("rst_rf_data", bus.rf_data, 0);
        check("rst_st_data", bus.st_data, 0);
        check("rst_wb_stall", bus.wb_stall, 0);
        check("rst_pend_count", bus.pend_count, 0);
        check("rst_md_ready", bus.md_ready, 1);
        reset = 1'b0;
        tick();

        // 1: single result through an idle pipeline, 2 cycles latency
        idle(); md(5, 32'h0000_002A, 0);
        tick();
        idle();
        check("t1_not_early", bus.rf_we, 0);
        tick();
        check("t1_rf_we", bus.rf_we, 1);
        check("t1_rf_rd", bus.rf_rd, 5);
        check("t1_rf_data", bus.rf_data, 32'h2A);
        check("t1_st_we", bus.st_we, 0);
        tick();

        // 2: pipeline hogs the port, FIFO fills, starvation stall, in-order drain
        for (int i = 0; i < 4; i++) begin
            idle();
            bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_data = 32'h3000 + i;
            md(REG_AW'(10 + i), 32'h100 + i, 0);
            tick();
        end
        idle();
        check("t2_full_ready", bus.md_ready, 0);
        check("t2_full_count", bus.pend_count, 4);
        for (int k = 5; k <= 9; k++) begin
            bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_data = 32'h3000 + k;
            tick();
            if (k == 8) check("t2_stall_not_yet", bus.wb_stall, 0);
            if (k == 9) check("t2_stall_set", bus.wb_stall, 1);
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_drain_we", bus.rf_we, 1);
            check("t2_drain_rd", bus.rf_rd, 10 + i);
            check("t2_drain_data", bus.rf_data, 32'h100 + i);
            if (i == 0) check("t2_stall_clear", bus.wb_stall, 0);
        end
        check("t2_empty", bus.pend_count, 0);
        tick();

        // 3: exception result deferred by two pipeline status writes
        idle(); md(7, 32'h77, 1);
        tick();
        idle(); bus.pipe_st_we = 1; bus.pipe_st_data = 32'hAA;
        tick();
        check("t3_defer1_rf", bus.rf_we, 0);
        check("t3_defer1_st", bus.st_data, 32'hAA);
        tick();
        check("t3_defer2_rf", bus.rf_we, 0);
        idle();
        tick();
        check("t3_rf_we", bus.rf_we, 1);
        check("t3_rf_rd", bus.rf_rd, 7);
        check("t3_rf_data", bus.rf_data, 32'h77);
        check("t3_st_we", bus.st_we, 1);
        check("t3_st_data", bus.st_data, 32'h0000_0001);
        tick();

        // 4: scoreboard queries, rd=0 handling
        idle(); md(0, 32'h55, 0);
        tick();
        idle();
        check("t4_drop", bus.pend_count, 0);
        bus.pipe_we = 1; md(9, 32'h99, 0);
        tick();
        idle(); bus.pipe_we = 1; md(0, 32'hEE, 1);
        tick();
        idle(); bus.pipe_we = 1;
        check("t4_pipe_rd0", bus.rf_we, 0);
        check("t4_count", bus.pend_count, 2);
        bus.q_rd = 9; #1;
        check("t4_hit9", bus.q_hit, 1);
        bus.q_rd = 0; #1;
        check("t4_hit0", bus.q_hit, 0);
        bus.q_rd = 3; #1;
        check("t4_hit3", bus.q_hit, 0);
        bus.pipe_we = 0;
        tick();
        check("t4_drain_rd", bus.rf_rd, 9);
        check("t4_drain_we", bus.rf_we, 1);
        bus.q_rd = 9; #1;
        check("t4_hit9_after", bus.q_hit, 0);
        tick();
        check("t4_exc_rf_we", bus.rf_we, 0);
        check("t4_exc_st_we", bus.st_we, 1);
        check("t4_exc_st_data", bus.st_data, 1);
        check("t4_empty", bus.pend_count, 0);
        idle();
        tick();

        // 5: full FIFO, drain plus offer in the same cycle, pointer wrap
        for (int i = 0; i < 4; i++) begin
            idle(); bus.pipe_we = 1; md(REG_AW'(16 + i), 32'h160 + i, 0);
            tick();
        end
        idle(); md(20, 32'h200, 0);
        #1;
        check("t5_full_ready", bus.md_ready, 0);
        tick();
        check("t5_count3", bus.pend_count, 3);
        check("t5_first", bus.rf_rd, 16);
        bus.pipe_we = 1;
        tick();
        check("t5_count4", bus.pend_count, 4);
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_order_rd", bus.rf_rd, (i < 3) ? 17 + i : 20);
            check("t5_order_data", bus.rf_data, (i < 3) ? 32'h161 + i : 32'h200);
        end
        tick();

        // 6: reset while draining with 3 entries pending
        for (int i = 0; i < 3; i++) begin
            idle(); bus.pipe_we = 1; md(REG_AW'(25 + i), 32'h250 + i, 0);
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rf_we", bus.rf_we, 0);
        check("t6_count", bus.pend_count, 0);
        check("t6_stall", bus.wb_stall, 0);
        check("t6_ready", bus.md_ready, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_no_stale", bus.rf_we, 0);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset = ($urandom_range(0, 499) == 0);
            bus.pipe_we      = ($urandom_range(0, 2) == 0);
            bus.pipe_rd      = REG_AW'($urandom_range(0, 7));
            bus.pipe_data    = $urandom;
            bus.pipe_st_we   = ($urandom_range(0, 4) == 0);
            bus.pipe_st_data = $urandom;
            if (bus.wb_stall && $urandom_range(0, 9) < 8) begin
                bus.pipe_we    = 0;
                bus.pipe_st_we = 0;
            end
            if ($urandom_range(0, 1) == 1)
                md(REG_AW'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 7) == 0));
            bus.q_rd = REG_AW'($urandom_range(0, 7));
            tick();
        end
        idle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
